// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head data comes straight from storage registers.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Flush wins over push/pop; storage keeps stale data since count gates visibility.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, prefetch queue handshake to decode, redirect handling.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap entry and id_misalign.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int ENTRY_W = $bits(fetch_entry_t);
`else
  localparam int ENTRY_W = 64;
`endif

  logic [31:0]        pc_q, pc_d;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] push_data, head_data;
  logic               push, pop, can_push;

  assign imem_addr = pc_q;
  assign id_valid  = (fifo_count != '0);
  assign pop       = id_valid & id_ready & ~redirect_valid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign can_push  = (fifo_count < CW'(FIFO_DEPTH)) | pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e state_q, state_d;
  logic [31:0]  trap_pc_q;
  fetch_entry_t push_entry, head_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      trap_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid) trap_pc_q <= redirect_pc;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = '{pc: pc_q, instr: imem_instr, misalign: 1'b0};
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      state_d = (redirect_pc[1:0] != 2'b00) ? TRAP : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (can_push) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        TRAP: begin
          push_entry = '{pc: trap_pc_q, instr: NOP_INSTR, misalign: 1'b1};
          if (can_push) begin
            push    = 1'b1;
            state_d = HALT;
          end
        end
        default: ;
      endcase
    end
  end

  assign push_data   = push_entry;
  assign head_entry  = fetch_entry_t'(head_data);
  assign id_pc       = head_entry.pc;
  assign id_instr    = head_entry.instr;
  assign id_misalign = head_entry.misalign;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  // Redirect targets are force-aligned; low bits are deliberately dropped.
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (can_push) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
    end
  end

  assign push_data = {pc_q, imem_instr};
  assign id_pc     = head_data[63:32];
  assign id_instr  = head_data[31:0];
`endif

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head_data),
    .count_o (fifo_count)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with program counter. It drives the word address into the combinational instruction memory and captures each returned instruction with its PC into a small prefetch queue. Decode consumes the queue through a valid/ready handshake, and branch/jump redirects from execute flush the queue and reload the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch queue entries; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_addr  out  32  byte address to instruction memory; equals pc_q.
- imem_instr  in  32  instruction word; valid combinationally in the same cycle.
- redirect_valid  in  1  flush and reload PC this cycle.
- redirect_pc  in  32  new PC when redirect_valid=1.
- id_valid  out  1  queue head holds an instruction.
- id_ready  in  1  decode accepts head this cycle.
- id_instr  out  32  head instruction.
- id_pc  out  32  PC of head instruction.
- id_misalign  out  1  head is a misaligned-fetch trap entry; present only with FETCH_MISALIGN_TRAP_EN.

## Operation
- The fetch unit presents pc_q on imem_addr every cycle. The memory indexes by addr[31:2].
- Push condition: no redirect, state RUN, and (count<FIFO_DEPTH or a pop occurs this cycle).
  - On push: write {pc_q, imem_instr} to the tail; pc_q <= pc_q+4.
  - pc_q wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- Pop condition: id_valid & id_ready & !redirect_valid. Head advances.
- Simultaneous push and pop: count unchanged. A push when full is allowed only alongside a pop.
- Redirect has priority over everything:
  - queue count <= 0 and pointers reset.
  - pc_q <= redirect_pc with bits[1:0] cleared.
  - Any same-cycle pop is discarded and not counted.
  - Without FETCH_MISALIGN_TRAP_EN, redirect_pc[1:0] are ignored.
- id_valid = (count≠0). id_instr and id_pc are the head entry and come from register outputs only; there is no combinational path from imem_instr.
- FSM (meaningful only with the macro; without it the state is constantly RUN):
  - RUN: normal fetch. A redirect with redirect_pc[1:0]≠0 → TRAP.
  - TRAP: push one entry {pc=redirect_pc unmodified, instr=32'h0000_0013, misalign=1} when space allows, then → HALT.
  - HALT: no pushes. Only a redirect leaves HALT: aligned → RUN, misaligned → TRAP.

## Timing
- Reset values: pc_q=RESET_PC, count=0, state=RUN, id_valid=0, id_instr=0, id_pc=0, id_misalign=0, imem_addr=RESET_PC.
- Reset asserted mid-operation clears the queue and PC immediately (asynchronously).
- First instruction: pushed on the first rising edge after rst_n deasserts; id_valid=1 in the following cycle.
- Redirect latency: redirect at edge N → imem_addr=redirect_pc during cycle N+1 → pushed at edge N+1 → id_valid during N+2. Two bubbles.
- Steady state with id_ready held high: one instruction per cycle.
- id_ready low: the queue fills to FIFO_DEPTH and pc_q holds. Restart has no bubble because a push is allowed alongside the pop.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - id_misalign port exists.
  - TRAP/HALT behaviour active; each queue entry stores a misalign bit.
- Undefined:
  - No id_misalign port and no misalign storage.
  - Redirect targets are force-aligned; the FSM reduces to RUN.

## Structure
- Shared package fetch_pkg holds:
  - NOP constant 32'h0000_0013.
  - Default reset PC constant.
  - Fetch state enum RUN/TRAP/HALT.
  - Queue entry struct {pc, instr, misalign}.
- Sub-module fetch_fifo: synchronous FIFO, parameterised by width/depth, with push/pop/flush, count, and an async active-low reset. fetch_unit contains the PC, the FSM and the handshake logic.

## Test plan
- Reset release, RESET_PC=0, memory words 0..3 = A,B,C,D, id_ready=1 → id_valid rises one cycle after the first edge; decode receives A,B,C,D with id_pc 0,4,8,C, one per cycle.
- Backpressure: id_ready=0 for 5 cycles → count saturates at 2, imem_addr stops at 8. Raise id_ready → A,B,C delivered back-to-back with no gap.
- Redirect to 32'h40 while the queue is full and id_ready=1 → the same-cycle pop is ignored, the queue is empty next cycle, and id_pc=32'h40 appears two cycles after the redirect.
- PC wrap: redirect to 32'hFFFF_FFFC → id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
- With FETCH_MISALIGN_TRAP_EN: redirect to 32'h102 → a single entry id_misalign=1, id_instr=32'h13, id_pc=32'h102; no further id_valid. A later redirect to 32'h200 resumes fetch at 32'h200.
- Without the macro: redirect to 32'h102 → fetch resumes at 32'h100.
